// File: rtl/sq_phase_gen_if.sv
// ---------------------------------------------------------------------------
// sq_phase_gen_if
// Configuration handshake between a controller and sq_phase_gen.
//   cfg_valid  : controller offers a configuration
//   cfg_ready  : generator can take a configuration this cycle
//   cfg_period : square-wave period in ticks
//   cfg_phase  : signed phase offset in degrees (positive = i lags v)
//   cfg_err    : one-cycle pulse, the offered configuration was illegal
// Modports: master (controller side), slave (generator side).
// ---------------------------------------------------------------------------
interface sq_phase_gen_if #(
  parameter int PERIOD_W = 24
) ();
  logic                cfg_valid;
  logic                cfg_ready;
  logic [PERIOD_W-1:0] cfg_period;
  logic signed [15:0]  cfg_phase;
  logic                cfg_err;

  modport master (output cfg_valid, cfg_period, cfg_phase,
                  input  cfg_ready, cfg_err);
  modport slave  (input  cfg_valid, cfg_period, cfg_phase,
                  output cfg_ready, cfg_err);
endinterface

// File: rtl/sq_phase_gen.sv
// ---------------------------------------------------------------------------
// sq_phase_gen
// Reference v/i square-wave pair with programmed period and signed phase
// offset, used to exercise the phase/frequency measurement path.
// Ports:
//   clk, rst     : clock, asynchronous active-low reset
//   enable       : run request; low parks the outputs
//   cfg          : configuration handshake (slave side)
//   v_square     : voltage square wave
//   i_square     : current square wave
//   square_done  : one-cycle tick strobe aligned with v/i updates
//   running      : high while the waveform is being generated
//   delay_ticks  : |phase| converted to ticks, floor(|phase|*period/360)
// ---------------------------------------------------------------------------
module sq_phase_gen #(
  parameter int PERIOD_W = 24,
  parameter int TICK_DIV = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                enable,
  sq_phase_gen_if.slave       cfg,
  output logic                v_square,
  output logic                i_square,
  output logic                square_done,
  output logic                running,
  output logic [PERIOD_W-1:0] delay_ticks
);
  localparam int PROD_W = PERIOD_W + 8;
  localparam int STEP_W = $clog2(PERIOD_W + 10);
  localparam int PRE_W  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(PERIOD_W + 9);
  localparam logic [PRE_W-1:0]  PRE_LAST  = PRE_W'(TICK_DIV - 1);
  localparam logic [9:0]        DIVISOR   = 10'd360;

  typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, RUN = 2'd2} state_t;

  state_t              state_r, state_nxt_s;
  logic [PERIOD_W-1:0] period_r, delay_r, vcnt_r, icnt_r, hold_r;
  logic [PERIOD_W-1:0] half_s, delay_src_s;
  logic [7:0]          mag_r, phase_mag_s;
  logic                neg_r, cfg_loaded_r, cfg_ready_r, cfg_err_r;
  logic                v_r, i_r, done_r, running_r;
  logic [STEP_W-1:0]   step_r;
  logic [PROD_W-1:0]   dq_r;
  logic [8:0]          rem_r;
  logic [9:0]          div_try_s;
  logic                div_ge_s;
  logic [PRE_W-1:0]    pre_r;
  logic                xfer_s, cfg_legal_s, accept_s, run_entry_s, tick_s;

  // Next counter value with wrap at period-1.
  function automatic logic [PERIOD_W-1:0] wrap_inc(input logic [PERIOD_W-1:0] c,
                                                   input logic [PERIOD_W-1:0] p);
    if (c == p - PERIOD_W'(1)) return '0;
    else return c + PERIOD_W'(1);
  endfunction

  assign xfer_s      = cfg.cfg_valid && cfg_ready_r;
  assign cfg_legal_s = (cfg.cfg_period >= PERIOD_W'(4)) &&
                       (cfg.cfg_phase >= -16'sd180) && (cfg.cfg_phase <= 16'sd180);
  assign accept_s    = xfer_s && cfg_legal_s;
  assign phase_mag_s = cfg.cfg_phase[15] ? 8'(16'd0 - cfg.cfg_phase) : cfg.cfg_phase[7:0];
  assign half_s      = period_r >> 1;
  assign div_try_s   = {rem_r, dq_r[PROD_W-1]};
  assign div_ge_s    = (div_try_s >= DIVISOR);
  // Entering RUN straight out of CALC, the fresh quotient is not yet in delay_r.
  assign delay_src_s = (state_r == CALC) ? dq_r[PERIOD_W-1:0] : delay_r;

  assign cfg.cfg_ready = cfg_ready_r;
  assign cfg.cfg_err   = cfg_err_r;
  assign v_square      = v_r;
  assign i_square      = i_r;
  assign square_done   = done_r;
  assign running       = running_r;
  assign delay_ticks   = delay_r;

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_r <= IDLE;
    else      state_r <= state_nxt_s;
  end

  // Next-state logic; an illegal offer leaves the state untouched.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (xfer_s) state_nxt_s = cfg_legal_s ? CALC : IDLE;
        else if (enable && cfg_loaded_r) state_nxt_s = RUN;
        else state_nxt_s = IDLE;
      end
      CALC: begin
        if (step_r == STEP_LAST) state_nxt_s = enable ? RUN : IDLE;
        else state_nxt_s = CALC;
      end
      RUN: begin
        if (xfer_s) state_nxt_s = cfg_legal_s ? CALC : RUN;
        else if (!enable) state_nxt_s = IDLE;
        else state_nxt_s = RUN;
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  assign run_entry_s = (state_nxt_s == RUN) && (state_r != RUN);
  assign tick_s      = (state_r == RUN) && (state_nxt_s == RUN) && (pre_r == PRE_LAST);

  // Handshake outputs and configuration store.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cfg_ready_r <= 1'b1;
      cfg_err_r   <= 1'b0;
      period_r    <= '0;
      mag_r       <= 8'd0;
      neg_r       <= 1'b0;
    end else begin
      cfg_ready_r <= (state_nxt_s != CALC);
      cfg_err_r   <= xfer_s && !cfg_legal_s;
      if (accept_s) begin
        period_r <= cfg.cfg_period;
        mag_r    <= phase_mag_s;
        neg_r    <= cfg.cfg_phase[15];
      end
    end
  end

  // Delay computation: product on step 0, one restoring-divide bit per step,
  // quotient published on the last step.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      step_r       <= '0;
      dq_r         <= '0;
      rem_r        <= 9'd0;
      delay_r      <= '0;
      cfg_loaded_r <= 1'b0;
    end else if (state_r == CALC) begin
      if (step_r == '0) begin
        dq_r   <= PROD_W'(mag_r) * PROD_W'(period_r);
        rem_r  <= 9'd0;
        step_r <= step_r + STEP_W'(1);
      end else if (step_r != STEP_LAST) begin
        dq_r   <= {dq_r[PROD_W-2:0], div_ge_s};
        rem_r  <= div_ge_s ? 9'(div_try_s - DIVISOR) : div_try_s[8:0];
        step_r <= step_r + STEP_W'(1);
      end else begin
        delay_r      <= dq_r[PERIOD_W-1:0];
        cfg_loaded_r <= 1'b1;
        step_r       <= '0;
      end
    end else begin
      step_r <= '0;
    end
  end

  // Waveform generation. Counters hold the value for the *next* tick, so the
  // entry edge already presents tick 0 on the outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pre_r <= '0; vcnt_r <= '0; icnt_r <= '0; hold_r <= '0;
      v_r <= 1'b0; i_r <= 1'b0; done_r <= 1'b0; running_r <= 1'b0;
    end else if (run_entry_s) begin
      pre_r     <= '0;
      done_r    <= 1'b1;
      running_r <= 1'b1;
      v_r       <= 1'b1;              // vcnt=0 is always below half (period >= 4)
      vcnt_r    <= PERIOD_W'(1);
      if (neg_r) begin
        // i leads: start its counter delay ticks ahead of v.
        i_r    <= (delay_src_s < half_s);
        icnt_r <= wrap_inc(delay_src_s, period_r);
        hold_r <= '0;
      end else if (delay_src_s == '0) begin
        i_r    <= 1'b1;
        icnt_r <= PERIOD_W'(1);
        hold_r <= '0;
      end else begin
        // i lags: keep it low for delay ticks, tick 0 is the first of them.
        i_r    <= 1'b0;
        icnt_r <= '0;
        hold_r <= delay_src_s - PERIOD_W'(1);
      end
    end else if (tick_s) begin
      pre_r     <= '0;
      done_r    <= 1'b1;
      running_r <= 1'b1;
      v_r       <= (vcnt_r < half_s);
      vcnt_r    <= wrap_inc(vcnt_r, period_r);
      if (hold_r != '0) begin
        i_r    <= 1'b0;
        hold_r <= hold_r - PERIOD_W'(1);
      end else begin
        i_r    <= (icnt_r < half_s);
        icnt_r <= wrap_inc(icnt_r, period_r);
      end
    end else if (state_nxt_s == RUN) begin
      pre_r     <= pre_r + PRE_W'(1);
      done_r    <= 1'b0;
      running_r <= 1'b1;
    end else begin
      pre_r     <= '0;
      v_r       <= 1'b0;
      i_r       <= 1'b0;
      done_r    <= 1'b0;
      running_r <= 1'b0;
    end
  end
endmodule

// File: tb/tb_sq_phase_gen.sv
module tb_sq_phase_gen;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, en1, en4;
  logic        v1, i1, sd1, run1, v4, i4, sd4, run4;
  logic [23:0] dly1, dly4;

  sq_phase_gen_if #(.PERIOD_W(24)) if1 ();
  sq_phase_gen_if #(.PERIOD_W(24)) if4 ();

  sq_phase_gen #(.PERIOD_W(24), .TICK_DIV(1)) dut1 (
    .clk(clk), .rst(rst), .enable(en1), .cfg(if1.slave),
    .v_square(v1), .i_square(i1), .square_done(sd1), .running(run1), .delay_ticks(dly1));

  sq_phase_gen #(.PERIOD_W(24), .TICK_DIV(4)) dut4 (
    .clk(clk), .rst(rst), .enable(en4), .cfg(if4.slave),
    .v_square(v4), .i_square(i4), .square_done(sd4), .running(run4), .delay_ticks(dly4));

  int total = 0;
  int bad   = 0;
  int tk, per, dly, mis;
  bit neg;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Closed-form reference: v high for the first floor(p/2) ticks of each period.
  function automatic logic mv(input int k, input int p);
    return (k % p) < (p / 2);
  endfunction

  // i lags by d (low before its first rise) or, for negative phase, leads by d.
  function automatic logic mi(input int k, input int p, input int d, input bit n);
    if (n) return ((k + d) % p) < (p / 2);
    else if (k < d) return 1'b0;
    else return ((k - d) % p) < (p / 2);
  endfunction

  task automatic run1_cycles(input int n);
    for (int c = 0; c < n; c++) begin
      @(posedge clk); @(negedge clk);
      tk++;
      if (v1 !== mv(tk, per) || i1 !== mi(tk, per, dly, neg) || sd1 !== 1'b1 || run1 !== 1'b1)
        mis++;
    end
  endtask

  task automatic offer1(input logic [23:0] p, input logic signed [15:0] ph);
    if1.cfg_valid = 1'b1; if1.cfg_period = p; if1.cfg_phase = ph;
    @(posedge clk); @(negedge clk);
    if1.cfg_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b0; en1 = 1'b0; en4 = 1'b0;
    if1.cfg_valid = 1'b0; if1.cfg_period = 24'd0; if1.cfg_phase = 16'sd0;
    if4.cfg_valid = 1'b0; if4.cfg_period = 24'd0; if4.cfg_phase = 16'sd0;
    repeat (3) @(negedge clk);
    chk("rst_ready", if1.cfg_ready, 1); chk("rst_run", run1, 0); chk("rst_v", v1, 0);
    chk("rst_i", i1, 0); chk("rst_sd", sd1, 0); chk("rst_err", if1.cfg_err, 0);
    chk("rst_dly", dly1, 0);
    rst = 1'b1;
    en1 = 1'b1;
    repeat (4) @(negedge clk);
    chk("idle_no_cfg", run1, 0);

    // T1: 1000 ticks, +90 deg
    offer1(24'd1000, 16'sd90);
    chk("t1_calc_ready", if1.cfg_ready, 0); chk("t1_calc_run", run1, 0);
    repeat (33) @(negedge clk);
    chk("t1_last_calc", run1, 0);
    @(negedge clk);
    chk("t1_run", run1, 1); chk("t1_delay", dly1, 250); chk("t1_ready", if1.cfg_ready, 1);
    chk("t1_v0", v1, 1); chk("t1_i0", i1, 0); chk("t1_sd0", sd1, 1);
    per = 1000; dly = 250; neg = 1'b0; tk = 0; mis = 0;
    run1_cycles(2100);
    chk("t1_wave", mis, 0);

    // T2: 800 ticks, -45 deg, offered while running
    offer1(24'd800, -16'sd45);
    chk("t2_abort_v", v1, 0); chk("t2_abort_i", i1, 0); chk("t2_abort_run", run1, 0);
    repeat (33) @(negedge clk);
    @(negedge clk);
    chk("t2_run", run1, 1); chk("t2_delay", dly1, 100);
    chk("t2_v0", v1, 1); chk("t2_i0", i1, 1);
    per = 800; dly = 100; neg = 1'b1; tk = 0; mis = 0;
    run1_cycles(1700);
    chk("t2_wave", mis, 0);

    // T3: illegal offers while running
    offer1(24'd3, 16'sd0);
    tk++;
    chk("t3_err_period", if1.cfg_err, 1); chk("t3_run", run1, 1);
    chk("t3_v", v1, mv(tk, per)); chk("t3_i", i1, mi(tk, per, dly, neg));
    mis = 0;
    run1_cycles(1);
    chk("t3_err_clear", if1.cfg_err, 0);
    offer1(24'd1000, 16'sd181);
    tk++;
    chk("t3_err_phase", if1.cfg_err, 1); chk("t3_dly_kept", dly1, 100);
    chk("t3_v2", v1, mv(tk, per)); chk("t3_i2", i1, mi(tk, per, dly, neg));
    run1_cycles(900);
    chk("t3_wave", mis, 0);

    // T4: reconfigure (1000,+90) -> (500,+180) while running
    offer1(24'd1000, 16'sd90);
    repeat (33) @(negedge clk);
    @(negedge clk);
    per = 1000; dly = 250; neg = 1'b0; tk = 0; mis = 0;
    run1_cycles(100);
    chk("t4_pre_wave", mis, 0);
    offer1(24'd500, 16'sd180);
    chk("t4_abort_v", v1, 0); chk("t4_abort_i", i1, 0); chk("t4_abort_sd", sd1, 0);
    chk("t4_abort_run", run1, 0); chk("t4_calc_ready", if1.cfg_ready, 0);
    repeat (4) @(negedge clk);
    offer1(24'd600, 16'sd0);
    chk("t4_calc_ignored", if1.cfg_err, 0);
    en1 = 1'b0;
    repeat (5) @(negedge clk);
    en1 = 1'b1;
    repeat (23) @(negedge clk);
    chk("t4_last_calc", run1, 0);
    @(negedge clk);
    chk("t4_run", run1, 1); chk("t4_delay", dly1, 250);
    chk("t4_v0", v1, 1); chk("t4_i0", i1, 0);
    per = 500; dly = 250; neg = 1'b0; tk = 0; mis = 0;
    run1_cycles(1200);
    chk("t4_wave", mis, 0);

    // Disable then re-enable from IDLE with the stored configuration
    en1 = 1'b0;
    @(negedge clk);
    chk("dis_run", run1, 0); chk("dis_v", v1, 0); chk("dis_i", i1, 0);
    chk("dis_sd", sd1, 0); chk("dis_ready", if1.cfg_ready, 1);
    en1 = 1'b1;
    @(negedge clk);
    chk("reen_run", run1, 1); chk("reen_v0", v1, 1); chk("reen_i0", i1, 0);
    tk = 0; mis = 0;
    run1_cycles(300);
    chk("reen_wave", mis, 0);

    // T6: asynchronous reset mid-RUN, then mid-CALC
    chk("t6_pre_i", i1, 1);
    #2 rst = 1'b0;
    #1;
    chk("t6_run_i", i1, 0); chk("t6_run_run", run1, 0); chk("t6_run_sd", sd1, 0);
    chk("t6_run_ready", if1.cfg_ready, 1); chk("t6_run_dly", dly1, 0);
    @(negedge clk); rst = 1'b1;
    repeat (5) @(negedge clk);
    chk("t6_no_restart", run1, 0);
    offer1(24'd1000, 16'sd90);
    repeat (10) @(negedge clk);
    chk("t6_in_calc", if1.cfg_ready, 0);
    #2 rst = 1'b0;
    #1;
    chk("t6_calc_ready", if1.cfg_ready, 1); chk("t6_calc_run", run1, 0);
    @(negedge clk); rst = 1'b1;
    repeat (50) @(negedge clk);
    chk("t6_calc_no_run", run1, 0); chk("t6_calc_dly", dly1, 0);

    // T5: TICK_DIV=4, period 10, phase 0
    en4 = 1'b1;
    if4.cfg_valid = 1'b1; if4.cfg_period = 24'd10; if4.cfg_phase = 16'sd0;
    @(posedge clk); @(negedge clk);
    if4.cfg_valid = 1'b0;
    repeat (33) @(negedge clk);
    chk("t5_last_calc", run4, 0);
    @(negedge clk);
    chk("t5_run", run4, 1); chk("t5_sd0", sd4, 1); chk("t5_v0", v4, 1);
    chk("t5_i0", i4, 1); chk("t5_delay", dly4, 0);
    mis = 0;
    for (int c = 1; c < 100; c++) begin
      @(negedge clk);
      if (sd4 !== ((c % 4) == 0) || v4 !== mv(c / 4, 10) || i4 !== v4 || run4 !== 1'b1)
        mis++;
    end
    chk("t5_wave", mis, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
